// File: rtl/wbu_arbiter.sv
// Two-master Wishbone pipeline arbiter (debug bus = A, CPU = B) with pipeline
// depth tracking and bus timeout. Optional macro: WBU_ARBITER_ROUND_ROBIN_EN.
module wbu_arbiter #(
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned LGTIMEOUT = 19,
  parameter int unsigned LGPIPE    = 4
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_a_cyc,
  input  logic          i_a_stb,
  input  logic          i_a_we,
  input  logic [AW-1:0] i_a_addr,
  input  logic [DW-1:0] i_a_data,
  output logic          o_a_ack,
  output logic          o_a_stall,
  output logic          o_a_err,
  output logic [DW-1:0] o_a_data,
  input  logic          i_b_cyc,
  input  logic          i_b_stb,
  input  logic          i_b_we,
  input  logic [AW-1:0] i_b_addr,
  input  logic [DW-1:0] i_b_data,
  output logic          o_b_ack,
  output logic          o_b_stall,
  output logic          o_b_err,
  output logic [DW-1:0] o_b_data,
  output logic          o_wb_cyc,
  output logic          o_wb_stb,
  output logic          o_wb_we,
  output logic [AW-1:0] o_wb_addr,
  output logic [DW-1:0] o_wb_data,
  input  logic          i_wb_ack,
  input  logic          i_wb_stall,
  input  logic          i_wb_err,
  input  logic [DW-1:0] i_wb_data,
  output logic [1:0]    o_owner,
  output logic          o_timeout
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_OWN_A = 2'b01,
    S_OWN_B = 2'b10,
    S_DRAIN = 2'b11
  } state_t;

  localparam logic [LGPIPE-1:0]    PIPE_MAX = '1;
  localparam logic [LGTIMEOUT-1:0] TMR_MAX  = '1;

  state_t               state, state_next;
  logic [LGPIPE-1:0]    npend, npend_next;
  logic [LGTIMEOUT-1:0] timer, timer_next;
  logic                 drain_b, drain_b_next;
  logic                 pick_a;

  logic own, sel_cyc, sel_stb, full, timeout, accept;
  logic ack_c, err_c, stall_c;

`ifdef WBU_ARBITER_ROUND_ROBIN_EN
  // Under contention, the master that did not own the bus last wins
  logic last_b;

  always_comb pick_a = i_a_cyc && (!i_b_cyc || last_b);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)
      last_b <= 1'b1;
    else if (state == S_IDLE && (i_a_cyc || i_b_cyc))
      last_b <= !pick_a;
  end
`else
  always_comb pick_a = i_a_cyc;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state   <= S_IDLE;
      npend   <= '0;
      timer   <= '0;
      drain_b <= 1'b0;
    end else begin
      state   <= state_next;
      npend   <= npend_next;
      timer   <= timer_next;
      drain_b <= drain_b_next;
    end
  end

  always_comb begin
    own          = (state == S_OWN_A) || (state == S_OWN_B);
    sel_cyc      = (state == S_OWN_B) ? i_b_cyc : i_a_cyc;
    sel_stb      = (state == S_OWN_B) ? i_b_stb : i_a_stb;
    full         = (npend == PIPE_MAX);
    timeout      = own && (timer == TMR_MAX);

    o_wb_we      = (state == S_OWN_B) ? i_b_we   : i_a_we;
    o_wb_addr    = (state == S_OWN_B) ? i_b_addr : i_a_addr;
    o_wb_data    = (state == S_OWN_B) ? i_b_data : i_a_data;
    o_a_data     = i_wb_data;
    o_b_data     = i_wb_data;
    o_wb_cyc     = 1'b0;
    o_wb_stb     = 1'b0;
    ack_c        = 1'b0;
    err_c        = 1'b0;
    stall_c      = 1'b1;
    o_a_ack      = 1'b0;
    o_a_err      = 1'b0;
    o_a_stall    = 1'b1;
    o_b_ack      = 1'b0;
    o_b_err      = 1'b0;
    o_b_stall    = 1'b1;
    o_owner      = state;
    o_timeout    = timeout;
    state_next   = state;
    npend_next   = '0;
    timer_next   = '0;
    drain_b_next = drain_b;

    if (own) begin
      // The timeout cycle also withdraws the bus so the slave sees the abort
      o_wb_cyc = sel_cyc && !timeout;
      o_wb_stb = sel_stb && !full && !timeout;
      ack_c    = i_wb_ack && (npend != '0);
      err_c    = i_wb_err || timeout;
      stall_c  = i_wb_stall || full || timeout;
    end

    if (state == S_OWN_B) begin
      o_b_ack   = ack_c;
      o_b_err   = err_c;
      o_b_stall = stall_c;
    end else if (state == S_OWN_A) begin
      o_a_ack   = ack_c;
      o_a_err   = err_c;
      o_a_stall = stall_c;
    end

    accept = o_wb_stb && !i_wb_stall;

    case (state)
      S_IDLE: begin
        if (pick_a)
          state_next = S_OWN_A;
        else if (i_b_cyc)
          state_next = S_OWN_B;
      end
      S_OWN_A, S_OWN_B: begin
        if (!sel_cyc) begin
          state_next = S_IDLE;
        end else if (i_wb_err || timeout) begin
          state_next   = S_DRAIN;
          drain_b_next = (state == S_OWN_B);
        end else begin
          case ({accept, ack_c})
            2'b10:   npend_next = npend + LGPIPE'(1);
            2'b01:   npend_next = npend - LGPIPE'(1);
            default: npend_next = npend;
          endcase
          if (!ack_c && (npend != '0))
            timer_next = timer + LGTIMEOUT'(1);
        end
      end
      default: begin
        if (!(drain_b ? i_b_cyc : i_a_cyc))
          state_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_wbu_arbiter.sv
// Directed self-checking bench for wbu_arbiter (default fixed-priority build,
// LGTIMEOUT=4, LGPIPE=2).
module tb_wbu_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_cyc, a_stb, a_we, b_cyc, b_stb, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdat, b_wdat;
  logic          a_ack, a_stall, a_err, b_ack, b_stall, b_err;
  logic [DW-1:0] a_rdat, b_rdat;
  logic          wb_cyc, wb_stb, wb_we;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_wdat, wb_rdat;
  logic          wb_ack, wb_stall, wb_err;
  logic [1:0]    owner;
  logic          tmo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wbu_arbiter #(.AW(AW), .DW(DW), .LGTIMEOUT(4), .LGPIPE(2)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_a_cyc(a_cyc), .i_a_stb(a_stb), .i_a_we(a_we), .i_a_addr(a_addr), .i_a_data(a_wdat),
    .o_a_ack(a_ack), .o_a_stall(a_stall), .o_a_err(a_err), .o_a_data(a_rdat),
    .i_b_cyc(b_cyc), .i_b_stb(b_stb), .i_b_we(b_we), .i_b_addr(b_addr), .i_b_data(b_wdat),
    .o_b_ack(b_ack), .o_b_stall(b_stall), .o_b_err(b_err), .o_b_data(b_rdat),
    .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we), .o_wb_addr(wb_addr),
    .o_wb_data(wb_wdat),
    .i_wb_ack(wb_ack), .i_wb_stall(wb_stall), .i_wb_err(wb_err), .i_wb_data(wb_rdat),
    .o_owner(owner), .o_timeout(tmo)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change here, outputs settle after #1
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1;
    {a_cyc, a_stb, a_we, b_cyc, b_stb, b_we} = '0;
    a_addr = '0; b_addr = '0; a_wdat = 32'h1111_1111; b_wdat = 32'h2222_2222;
    {wb_ack, wb_stall, wb_err} = '0;
    wb_rdat = '0;

    #1;
    chk("rst_owner", owner, 2'b00);
    chk("rst_cyc", wb_cyc, 1'b0);
    chk("rst_a_stall", a_stall, 1'b1);
    chk("rst_b_stall", b_stall, 1'b1);
    chk("rst_timeout", tmo, 1'b0);
    tick(); tick();
    rst = 1'b0;

    // A read while B idle
    tick();
    a_cyc = 1'b1; a_stb = 1'b1; a_addr = 32'h100;
    #1;
    chk("rd_idle_owner", owner, 2'b00);
    chk("rd_idle_stall", a_stall, 1'b1);
    tick();
    chk("rd_owner", owner, 2'b01);
    chk("rd_wb_cyc", wb_cyc, 1'b1);
    chk("rd_wb_stb", wb_stb, 1'b1);
    chk("rd_wb_addr", wb_addr, 32'h100);
    chk("rd_a_stall", a_stall, 1'b0);
    tick();
    a_stb = 1'b0;
    tick(); tick();
    wb_ack = 1'b1; wb_rdat = 32'hDEAD_BEEF;
    #1;
    chk("rd_a_ack", a_ack, 1'b1);
    chk("rd_a_data", a_rdat, 32'hDEAD_BEEF);
    chk("rd_b_ack", b_ack, 1'b0);
    tick();
    wb_ack = 1'b0; a_cyc = 1'b0;
    #1;
    chk("rd_drop_cyc", wb_cyc, 1'b0);
    tick();
    chk("rd_back_idle", owner, 2'b00);

    // Contention: A wins, B waits for one IDLE clock after A releases
    a_cyc = 1'b1; a_stb = 1'b1; b_cyc = 1'b1; b_stb = 1'b1; b_we = 1'b1;
    b_addr = 32'h200;
    tick();
    chk("ct_owner_a", owner, 2'b01);
    chk("ct_b_stall", b_stall, 1'b1);
    chk("ct_addr_a", wb_addr, 32'h100);
    tick();
    a_stb = 1'b0; wb_ack = 1'b1;
    #1;
    chk("ct_a_ack", a_ack, 1'b1);
    chk("ct_b_noack", b_ack, 1'b0);
    tick();
    wb_ack = 1'b0; a_cyc = 1'b0;
    tick();
    chk("ct_gap_idle", owner, 2'b00);
    chk("ct_gap_bstall", b_stall, 1'b1);
    tick();
    chk("ct_owner_b", owner, 2'b10);
    chk("ct_addr_b", wb_addr, 32'h200);
    chk("ct_b_we", wb_we, 1'b1);
    chk("ct_b_go", b_stall, 1'b0);

    // Slave error on B write
    tick();
    b_stb = 1'b0; wb_err = 1'b1;
    #1;
    chk("er_b_err", b_err, 1'b1);
    chk("er_a_err", a_err, 1'b0);
    tick();
    wb_err = 1'b0;
    #1;
    chk("er_drain", owner, 2'b11);
    chk("er_cyc_low", wb_cyc, 1'b0);
    chk("er_b_stall", b_stall, 1'b1);
    chk("er_no_err", b_err, 1'b0);
    tick();
    chk("er_hold", owner, 2'b11);
    b_cyc = 1'b0; b_we = 1'b0;
    tick();
    chk("er_release", owner, 2'b00);

    // Hung slave: timeout after 15 clocks with one request outstanding
    a_cyc = 1'b1; a_stb = 1'b1;
    tick();
    chk("to_owner", owner, 2'b01);
    tick();
    a_stb = 1'b0;
    repeat (14) tick();
    chk("to_not_yet", tmo, 1'b0);
    chk("to_no_err", a_err, 1'b0);
    tick();
    chk("to_pulse", tmo, 1'b1);
    chk("to_a_err", a_err, 1'b1);
    chk("to_cyc_low", wb_cyc, 1'b0);
    tick();
    chk("to_drain", owner, 2'b11);
    chk("to_one_shot", tmo, 1'b0);
    a_cyc = 1'b0;
    tick();
    chk("to_idle", owner, 2'b00);

    // Pipeline full at 3 outstanding
    a_cyc = 1'b1; a_stb = 1'b1;
    tick();
    tick(); tick(); tick();
    chk("pf_stall", a_stall, 1'b1);
    chk("pf_stb_low", wb_stb, 1'b0);
    chk("pf_cyc", wb_cyc, 1'b1);
    wb_ack = 1'b1;
    #1;
    chk("pf_ack", a_ack, 1'b1);
    tick();
    wb_ack = 1'b0;
    #1;
    chk("pf_room", a_stall, 1'b0);
    chk("pf_stb_go", wb_stb, 1'b1);
    tick();
    chk("pf_full_again", a_stall, 1'b1);
    a_stb = 1'b0; a_cyc = 1'b0;
    tick();
    wb_ack = 1'b1;
    #1;
    chk("pf_late_ack", a_ack, 1'b0);
    wb_ack = 1'b0;

    // Reset mid-cycle while B owns the bus
    b_cyc = 1'b1; b_stb = 1'b1;
    tick();
    chk("rs_owner_b", owner, 2'b10);
    chk("rs_cyc_hi", wb_cyc, 1'b1);
    rst = 1'b1;
    #1;
    chk("rs_cyc_low", wb_cyc, 1'b0);
    chk("rs_owner", owner, 2'b00);
    b_cyc = 1'b0; b_stb = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    wb_ack = 1'b1; wb_err = 1'b1;
    #1;
    chk("rs_no_ack", b_ack, 1'b0);
    chk("rs_no_err", b_err, 1'b0);
    chk("rs_idle", owner, 2'b00);
    wb_ack = 1'b0; wb_err = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wbu_arbiter.md
Name: wbu_arbiter

Overview:
Two-master Wishbone pipeline arbiter. It shares the single bus master port between the debug bus (master A, from the byte-serial wishbone command path) and a second master such as the CPU (master B).
- Grants ownership per bus cycle and holds it while the owner keeps CYC asserted.
- Tracks outstanding requests and aborts hung transactions with a timeout that returns an error to the owner.
- Sits between the masters and the peripheral interconnect.

Parameters:
AW, 32, address width
DW, 32, data width
LGTIMEOUT, 19, log2 of the bus timeout in clocks
LGPIPE, 4, width of the outstanding-request counter; max outstanding = 2^LGPIPE-1

Ports:
i_clk  in  1  system clock
i_reset  in  1  asynchronous, active-high reset
i_a_cyc, i_a_stb, i_a_we  in  1 each  master A bus request
i_a_addr  in  AW  master A address
i_a_data  in  DW  master A write data
o_a_ack, o_a_stall, o_a_err  out  1 each  master A response
o_a_data  out  DW  master A read data
i_b_cyc, i_b_stb, i_b_we, i_b_addr, i_b_data  in  1/1/1/AW/DW  master B request
o_b_ack, o_b_stall, o_b_err, o_b_data  out  1/1/1/DW  master B response
o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  arbitrated bus
o_wb_addr  out  AW  arbitrated address
o_wb_data  out  DW  arbitrated write data
i_wb_ack, i_wb_stall, i_wb_err  in  1 each  slave response
i_wb_data  in  DW  slave read data
o_owner  out  2  current state code (00 idle, 01 A, 10 B, 11 drain)
o_timeout  out  1  one-cycle pulse when a timeout abort fires

Behaviour:
- Registered FSM with states IDLE, OWN_A, OWN_B, DRAIN. Reset value: IDLE, counters 0, o_timeout 0.
- Bus outputs are combinational from the state and the owner's request lines. Async reset drops o_wb_cyc/o_wb_stb in the same instant.
- IDLE:
  - o_wb_cyc=0, o_wb_stb=0; both o_x_stall=1; all ack/err=0.
  - Arbitration: if i_a_cyc go to OWN_A; else if i_b_cyc go to OWN_B. Fixed priority to A.
  - Grant latency is 1 clock from CYC rising to the owner's first possible accept.
- OWN_x:
  - Pass-through: o_wb_cyc=i_x_cyc; o_wb_stb=i_x_stb && !full; we/addr/data from x.
  - o_x_stall = i_wb_stall || full; o_x_ack = i_wb_ack && (npend!=0); o_x_err = i_wb_err.
  - Non-owner sees stall=1, ack=0, err=0.
  - o_a_data = o_b_data = i_wb_data always.
- npend counter: +1 on accepted stb (o_wb_stb && !i_wb_stall), -1 on forwarded ack; simultaneous events leave it unchanged. full = (npend == 2^LGPIPE-1).
- Exits from OWN_x:
  - i_x_cyc=0: go to IDLE, npend cleared. Acks arriving later are dropped.
  - i_wb_err: forwarded the same cycle, then go to DRAIN.
- Timeout counter:
  - Clears on ack, on npend==0, and outside OWN_x; otherwise increments.
  - When all ones: o_x_err=1 and o_timeout=1 for one cycle, o_wb_cyc forced 0 that cycle, go to DRAIN.
- DRAIN: o_wb_cyc=0, owner stall=1, no ack/err. Stays until the former owner's i_x_cyc=0, then IDLE. npend and timer cleared.
- At least one IDLE clock always separates two ownerships. A master may not be starved by its own back-to-back cycles; with priority A, B waits while A re-requests.

Optional Feature:
Macro WBU_ARBITER_ROUND_ROBIN_EN.
- Defined: a 1-bit last-owner register, reset to B, is updated on each grant. In IDLE with both cyc high, the master that was not last owner wins.
- Undefined: fixed priority to A, and no last-owner register exists.

Test Plan:
- A read while B idle: A cyc/stb at addr 0x100, slave acks after 3 clocks with data 0xDEADBEEF → o_owner=01 one clock after cyc; o_a_ack with o_a_data=0xDEADBEEF; o_b_ack never set.
- Both request in the same clock: without macro → A granted, B stalled until A drops cyc, then B granted after one IDLE clock. With macro, second contention → B granted first.
- Hung slave, LGTIMEOUT=4: A stb accepted, no ack → after 15 clocks o_a_err=1, o_timeout=1, o_wb_cyc=0, state 11. A drops cyc → state 00.
- Slave err on B write → o_b_err same clock; next clock o_wb_cyc=0 while B holds cyc; state 11 until B releases.
- Pipeline full, LGPIPE=2: 3 stb accepted with no ack → o_a_stall=1 and o_wb_stb=0; one ack → one more stb accepted.
- Reset asserted mid-cycle in OWN_B → o_wb_cyc=0 immediately, o_owner=00, no spurious ack/err after release.
